// File: rtl/mul_pkg.sv
// Shared types for the pipelined M-extension multiplier.
// Operation encoding, per-stage control bundle and pipeline depth.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  localparam int MUL_LAT = 3;

  // Two's complement magnitude; 0x80000000 maps to itself (read unsigned).
  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mul_operand_prep.sv
// Sign handling ahead of the unsigned multiplier array:
// operand magnitudes plus the result negate flag.
module mul_operand_prep
  import mul_pkg::*;
(
  input  mul_op_e     op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] opa_o,
  output logic [31:0] opb_o,
  output logic        negate_o
);

  logic sa;
  logic sb;

  assign sa = rs1_i[31];
  assign sb = rs2_i[31];

  always_comb begin
    opa_o    = rs1_i;
    opb_o    = rs2_i;
    negate_o = 1'b0;
    unique case (1'b1)
      (op_i == MUL) || (op_i == MULH): begin
        opa_o    = mag32(rs1_i);
        opb_o    = mag32(rs2_i);
        negate_o = sa ^ sb;
      end
      (op_i == MULHSU): begin
        opa_o    = mag32(rs1_i);
        negate_o = sa;
      end
      (op_i == MULHU): begin
        negate_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_pipe_ctrl.sv
// Control for the X/M/W multiplier pipeline: handshakes, stalls, flush.
// Optional perf counters under `ifdef MUL_PERF_CNT_EN.
module mul_pipe_ctrl
  import mul_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             x_en,
  output logic             m_en,
  output logic             w_en,
  output logic [31:0]      x_opa,
  output logic [31:0]      x_opb,
  output logic [1:0]       s3_op,
  output logic             s3_negate,
  input  logic [31:0]      dp_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  output logic             busy
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_issued,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  typedef struct packed {
    mul_op_e          op;
    logic             negate;
    logic [TAG_W-1:0] tag;
  } mul_stage_t;

  logic [MUL_LAT-1:0] v_q;
  logic [MUL_LAT-1:0] v_d;
  mul_stage_t s1_q;
  mul_stage_t s2_q;
  mul_stage_t s3_q;
  mul_stage_t s1_d;

  logic adv1;
  logic adv2;
  logic adv3;
  logic neg;

  mul_operand_prep u_prep (
    .op_i     (mul_op_e'(req_op)),
    .rs1_i    (req_rs1),
    .rs2_i    (req_rs2),
    .opa_o    (x_opa),
    .opb_o    (x_opb),
    .negate_o (neg)
  );

  // A stage may move only if the one downstream is empty or leaving.
  assign adv3 = v_q[2] & rsp_ready;
  assign adv2 = v_q[1] & (!v_q[2] | adv3);
  assign adv1 = v_q[0] & (!v_q[1] | adv2);

  assign req_ready = !flush & (!v_q[0] | adv1);
  assign x_en      = req_valid & req_ready;
  assign m_en      = adv1;
  assign w_en      = adv2;

  always_comb begin
    s1_d.op     = mul_op_e'(req_op);
    s1_d.negate = neg;
    s1_d.tag    = req_tag;
    v_d[0] = x_en | (v_q[0] & !adv1);
    v_d[1] = adv1 | (v_q[1] & !adv2);
    v_d[2] = adv2 | (v_q[2] & !adv3);
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      v_q <= v_d;
      if (x_en) s1_q <= s1_d;
      if (m_en) s2_q <= s1_q;
      if (w_en) s3_q <= s2_q;
    end
  end

  assign rsp_valid = v_q[2];
  assign rsp_tag   = s3_q.tag;
  assign rsp_data  = dp_result;
  assign s3_op     = s3_q.op;
  assign s3_negate = s3_q.negate;
  assign busy      = |v_q;

`ifdef MUL_PERF_CNT_EN
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (x_en) issued_q <= issued_q + CNT_W'(1);
      if (v_q[2] & !rsp_ready) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Directed bench for mul_pipe_ctrl: latency, sign prep, stalls,
// flush and async reset; perf counters when MUL_PERF_CNT_EN is set.
module tb_mul_pipe_ctrl;

  localparam int TAG_W = 5;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             x_en;
  logic             m_en;
  logic             w_en;
  logic [31:0]      x_opa;
  logic [31:0]      x_opb;
  logic [1:0]       s3_op;
  logic             s3_negate;
  logic [31:0]      dp_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic             busy;
`ifdef MUL_PERF_CNT_EN
  logic [CNT_W-1:0] perf_issued;
  logic [CNT_W-1:0] perf_stall;
`endif

  int n_chk;
  int n_fail;

  mul_pipe_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_tag   (req_tag),
    .flush     (flush),
    .x_en      (x_en),
    .m_en      (m_en),
    .w_en      (w_en),
    .x_opa     (x_opa),
    .x_opb     (x_opb),
    .s3_op     (s3_op),
    .s3_negate (s3_negate),
    .dp_result (dp_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef MUL_PERF_CNT_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rsp_valid got %b want 0", rsp_valid);
    end
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_req_ready got %b want 1", req_ready);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    n_chk++;
    if ({x_en, m_en, w_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_en got %b want 000", {x_en, m_en, w_en});
    end
    n_chk++;
    if ({s3_op, s3_negate} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_s3 got %b want 000", {s3_op, s3_negate});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mulh();
    tick();
    rsp_ready = 1'b1;
    dp_result = 32'h1234_5678;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_rs1   = 32'hFFFF_FFFE;
    req_rs2   = 32'h0000_0003;
    req_tag   = 5'd5;
    @(negedge clk);
    n_chk++;
    if (x_opa !== 32'd2 || x_opb !== 32'd3) begin
      n_fail++;
      $display("FAIL mulh_ops got %h %h want 2 3", x_opa, x_opb);
    end
    n_chk++;
    if (x_en !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mulh_accept got %b%b want 11", x_en, req_ready);
    end
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mulh_early cyc %0d got %b want 0", i, rsp_valid);
      end
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 5'd5) begin
      n_fail++;
      $display("FAIL mulh_rsp got v=%b tag=%0d want v=1 tag=5",
               rsp_valid, rsp_tag);
    end
    n_chk++;
    if (s3_op !== 2'b01 || s3_negate !== 1'b1) begin
      n_fail++;
      $display("FAIL mulh_s3 got op=%b neg=%b want 01 1", s3_op, s3_negate);
    end
    n_chk++;
    if (rsp_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mulh_data got %h want 12345678", rsp_data);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mulh_drain got busy=%b v=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_signs();
    tick();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_rs1   = 32'h8000_0000;
    req_rs2   = 32'hFFFF_FFFF;
    req_tag   = 5'd1;
    @(negedge clk);
    n_chk++;
    if (x_opa !== 32'h8000_0000 || x_opb !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL mulhsu_ops got %h %h want 80000000 ffffffff",
               x_opa, x_opb);
    end
    tick();
    req_op  = 2'b11;
    req_tag = 5'd2;
    @(negedge clk);
    n_chk++;
    if (x_opa !== 32'h8000_0000 || x_opb !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL mulhu_ops got %h %h want 80000000 ffffffff",
               x_opa, x_opb);
    end
    tick();
    req_valid = 1'b0;
    req_op    = 2'b00;
    @(negedge clk);
    n_chk++;
    if (x_opa !== 32'h8000_0000 || x_opb !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL mul_ops got %h %h want 80000000 00000001",
               x_opa, x_opb);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 5'd1 ||
        s3_op !== 2'b10 || s3_negate !== 1'b1) begin
      n_fail++;
      $display("FAIL mulhsu_s3 got v=%b tag=%0d op=%b neg=%b want 1 1 10 1",
               rsp_valid, rsp_tag, s3_op, s3_negate);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 5'd2 ||
        s3_op !== 2'b11 || s3_negate !== 1'b0) begin
      n_fail++;
      $display("FAIL mulhu_s3 got v=%b tag=%0d op=%b neg=%b want 1 2 11 0",
               rsp_valid, rsp_tag, s3_op, s3_negate);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0] exp_tag;
    tick();
    rsp_ready = 1'b0;
    dp_result = 32'hCAFE_0000;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_rs1   = 32'd7;
    req_rs2   = 32'd9;
    for (int i = 0; i < 3; i++) begin
      req_tag = 5'(10 + i);
      @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_accept %0d got %b want 1", i, req_ready);
      end
      tick();
    end
    req_tag = 5'd13;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_tag !== 5'd10 ||
          rsp_data !== 32'hCAFE_0000) begin
        n_fail++;
        $display("FAIL b2b_hold %0d got rdy=%b v=%b tag=%0d d=%h want 0 1 10 cafe0000",
                 i, req_ready, rsp_valid, rsp_tag, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || x_en !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release got rdy=%b x_en=%b want 1 1", req_ready, x_en);
    end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_tag = 5'(11 + i);
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_tag !== exp_tag) begin
        n_fail++;
        $display("FAIL b2b_drain %0d got v=%b tag=%0d want 1 %0d",
                 i, rsp_valid, rsp_tag, exp_tag);
      end
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_empty got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_flush();
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_tag = 5'(20 + i);
      tick();
    end
    req_tag   = 5'd23;
    flush     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0 || x_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready got rdy=%b x_en=%b want 0 0", req_ready, x_en);
    end
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 5'd20 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_rsp got v=%b tag=%0d busy=%b want 1 20 1",
               rsp_valid, rsp_tag, busy);
    end
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_after %0d got busy=%b v=%b want 0 0",
                 i, busy, rsp_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_tag   = 5'd7;
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 ||
        {x_en, m_en, w_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid got v=%b busy=%b en=%b want 0 0 000",
               rsp_valid, busy, {x_en, m_en, w_en});
    end
    tick();
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rel got rdy=%b v=%b want 1 0", req_ready, rsp_valid);
    end
    tick();
    req_valid = 1'b1;
    req_tag   = 5'd9;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_early %0d got %b want 0", i, rsp_valid);
      end
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 5'd9) begin
      n_fail++;
      $display("FAIL rstmid_rsp got v=%b tag=%0d want 1 9", rsp_valid, rsp_tag);
    end
    tick();
  endtask

`ifdef MUL_PERF_CNT_EN
  task automatic test_perf();
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_tag   = 5'd1;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_tag = 5'(2 + i);
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if (perf_issued !== 32'd5) begin
      n_fail++;
      $display("FAIL perf_issued got %0d want 5", perf_issued);
    end
    n_chk++;
    if (perf_stall !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_stall got %0d want 2", perf_stall);
    end
  endtask
`endif

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_rs1   = '0;
    req_rs2   = '0;
    req_tag   = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    dp_result = '0;
    test_reset();
    test_mulh();
    test_signs();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef MUL_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
